// File: rtl/move_sequencer_if.sv
// Collision-checker bus between move_sequencer (master) and collision_checker (slave).
interface move_sequencer_if;
  logic cc_reset;
  logic cc_check;
  logic cc_load;
  logic cc_left;
  logic cc_right;
  logic cc_down;
  logic cc_out;
  logic cc_done;

  modport master (
    output cc_reset, cc_check, cc_load, cc_left, cc_right, cc_down,
    input  cc_out, cc_done
  );

  modport slave (
    input  cc_reset, cc_check, cc_load, cc_left, cc_right, cc_down,
    output cc_out, cc_done
  );
endinterface

// File: rtl/move_sequencer.sv
// Arbitrates spawn/gravity/down/left/right move requests onto the shared collision checker.
// Optional watchdog on the WAIT state is enabled by defining MOVE_SEQ_TIMEOUT_EN.
module move_sequencer #(
  parameter int TIMEOUT = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic                    req_spawn,
  input  logic                    req_gravity,
  input  logic                    req_down,
  input  logic                    req_left,
  input  logic                    req_right,
  move_sequencer_if.master        cc,
  output logic                    commit_left,
  output logic                    commit_right,
  output logic                    commit_down,
  output logic                    lock,
  output logic                    game_over,
  output logic                    busy,
  output logic                    timeout_err
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] CLEAR   = 3'd1;
  localparam logic [2:0] CHECK   = 3'd2;
  localparam logic [2:0] WAIT    = 3'd3;
  localparam logic [2:0] RESOLVE = 3'd4;

  logic [2:0] state;
  // pending/reqs/avail/grant bit order: {spawn, gravity, down, left, right}
  logic [4:0] pending;
  logic [4:0] reqs;
  logic [4:0] avail;
  logic [4:0] grant;
  // kind bit order: {load, down, left, right}
  logic [3:0] kind;
  logic       collided;
  logic       game_over_q;
  logic       active;
  logic       resolving;

  assign reqs  = {req_spawn, req_gravity, req_down, req_left, req_right};
  assign avail = pending | reqs;

  // A request pulse is visible to the arbiter in the same cycle it arrives.
  always_comb begin
    grant = 5'b0;
    if (state == IDLE && enable && !game_over_q) begin
      if (avail[4])      grant[4] = 1'b1;
      else if (avail[3]) grant[3] = 1'b1;
      else if (avail[2]) grant[2] = 1'b1;
      else if (avail[1]) grant[1] = 1'b1;
      else if (avail[0]) grant[0] = 1'b1;
    end
  end

`ifdef MOVE_SEQ_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] wait_cnt;
  logic          timeout_q;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      pending     <= 5'b0;
      kind        <= 4'b0;
      collided    <= 1'b0;
      game_over_q <= 1'b0;
`ifdef MOVE_SEQ_TIMEOUT_EN
      wait_cnt    <= '0;
      timeout_q   <= 1'b0;
`endif
    end else begin
      // A bit granted while already pending and re-requested in the same cycle stays set.
      if (game_over_q)
        pending <= 5'b0;
      else
        pending <= (pending & ~grant) | (reqs & ~(grant & ~pending));

      case (state)
        IDLE: begin
          if (|grant) begin
            state <= CLEAR;
            kind  <= {grant[4], grant[3] | grant[2], grant[1], grant[0]};
          end
        end
        CLEAR: state <= CHECK;
        CHECK: begin
          state <= WAIT;
`ifdef MOVE_SEQ_TIMEOUT_EN
          wait_cnt <= '0;
`endif
        end
        WAIT: begin
          if (cc.cc_done) begin
            state    <= RESOLVE;
            collided <= cc.cc_out;
            if (cc.cc_out && kind[3]) begin
              game_over_q <= 1'b1;
              pending     <= 5'b0;
            end
          end
`ifdef MOVE_SEQ_TIMEOUT_EN
          else if (wait_cnt == CW'(TIMEOUT - 1)) begin
            state     <= IDLE;
            timeout_q <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
`endif
        end
        RESOLVE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign active    = (state == CLEAR) || (state == CHECK) || (state == WAIT);
  assign resolving = (state == RESOLVE);

  assign cc.cc_reset = reset | (state == CLEAR);
  assign cc.cc_check = (state == CHECK);
  assign cc.cc_load  = active & kind[3];
  assign cc.cc_down  = active & kind[2];
  assign cc.cc_left  = active & kind[1];
  assign cc.cc_right = active & kind[0];

  assign commit_down  = resolving & ~collided & kind[2];
  assign commit_left  = resolving & ~collided & kind[1];
  assign commit_right = resolving & ~collided & kind[0];
  assign lock         = resolving &  collided & kind[2];
  assign game_over    = game_over_q;
  assign busy         = (state != IDLE);

`ifdef MOVE_SEQ_TIMEOUT_EN
  assign timeout_err = timeout_q;
`else
  assign timeout_err = 1'b0;
`endif

endmodule
